// File: rtl/mem_sweep_pkg.sv
// Shared definitions for RAM-consumer stages of the mem sweep engine:
// FSM state encoding, default bus widths and the legal RAM read-latency range.
package mem_sweep_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;
  localparam int SW_DEF = 32;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  // Counter holds RD_LAT-1, so RD_LAT_MAX-1 must fit.
  localparam int LAT_CW = $clog2(RD_LAT_MAX);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } sweep_state_t;

endpackage

// File: rtl/mem_rmw_sweep_if.sv
// Host control/status plus single-port RAM port of the read-modify-write sweeper.
// master = the sweeper, slave = host and RAM side.
interface mem_rmw_sweep_if
  import mem_sweep_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int SW = SW_DEF
);

  logic          start;
  logic [AW-1:0] base;
  logic [AW-1:0] len;
  logic          busy;
  logic          done;
  logic [SW-1:0] sum;
  logic [AW-1:0] addra;
  logic          wea;
  logic [DW-1:0] dina;
  logic [DW-1:0] douta;

  modport master (
    input  start, base, len, douta,
    output busy, done, sum, addra, wea, dina
  );

  modport slave (
    output start, base, len, douta,
    input  busy, done, sum, addra, wea, dina
  );

endinterface

// File: rtl/mem_sweep_lat_cnt.sv
// Loadable down-counter that marks RAM read data valid once it reaches zero.
// Load wins over decrement; decrement stops at zero.
module mem_sweep_lat_cnt #(
  parameter int CW = 2
) (
  input  logic          clka,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clka) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_rmw_sweep.sv
// Read-modify-write sweep mem[a] <= mem[a] + a over [base, base+len) with a
// running sum of the pre-update words; RD_LAT+2 cycles per word, no address skew.
module mem_rmw_sweep
  import mem_sweep_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int SW     = SW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic             clka,
  input  logic             rst,
  mem_rmw_sweep_if.master  bus
);

  localparam int RD_LAT_C = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                            (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam logic [LAT_CW-1:0] LAT_LOAD = LAT_CW'(RD_LAT_C - 1);

  sweep_state_t  state;
  logic [AW-1:0] cur;
  logic [AW-1:0] remaining;
  logic [AW-1:0] addra_q;
  logic          wea_q;
  logic          busy_q;
  logic          done_q;
  logic [SW-1:0] sum_q;
  logic          lat_zero;

  mem_sweep_lat_cnt #(
    .CW (LAT_CW)
  ) u_lat_cnt (
    .clka     (clka),
    .rst      (rst),
    .load     (state == ST_READ),
    .load_val (LAT_LOAD),
    .dec      (state == ST_WAIT),
    .zero     (lat_zero)
  );

  always_ff @(posedge clka) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur       <= '0;
      remaining <= '0;
      addra_q   <= '0;
      wea_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            cur       <= bus.base;
            remaining <= bus.len;
            sum_q     <= '0;
            if (bus.len == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              addra_q <= bus.base;
              busy_q  <= 1'b1;
              state   <= ST_READ;
            end
          end
        end
        ST_READ: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_zero) begin
            wea_q <= 1'b1;
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // addra only moves on the edge that drops wea, keeping read and write aligned.
          wea_q <= 1'b0;
          sum_q <= sum_q + SW'(bus.douta);
          if (remaining == AW'(1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else begin
            remaining <= remaining - AW'(1);
            cur       <= cur + AW'(1);
            addra_q   <= cur + AW'(1);
            state     <= ST_READ;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.addra = addra_q;
  assign bus.wea   = wea_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  // Only dina sees douta combinationally; it is forced to zero outside WRITE.
  assign bus.dina  = (state == ST_WRITE) ? DW'(bus.douta + DW'(cur)) : '0;

endmodule

// File: tb/tb_mem_rmw_sweep.sv
// Two sweepers (RD_LAT 1 and 3) on behavioural RAMs; a reference memory model
// predicts every write and done pulse, checked by a free-running monitor.
module tb_mem_rmw_sweep;
  import mem_sweep_pkg::*;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clka = 1'b0;
  logic rst;
  always #5 clka = ~clka;

  mem_rmw_sweep_if #(.AW(16), .DW(16), .SW(32)) ifc0 ();
  mem_rmw_sweep_if #(.AW(16), .DW(16), .SW(32)) ifc1 ();

  mem_rmw_sweep #(.AW(16), .DW(16), .SW(32), .RD_LAT(LAT0)) dut0 (
    .clka (clka), .rst (rst), .bus (ifc0.master));
  mem_rmw_sweep #(.AW(16), .DW(16), .SW(32), .RD_LAT(LAT1)) dut1 (
    .clka (clka), .rst (rst), .bus (ifc1.master));

  logic [15:0] addra_a [2];
  logic [15:0] dina_a  [2];
  logic        wea_a   [2];
  logic        busy_a  [2];
  logic        done_a  [2];
  logic [31:0] sum_a   [2];

  always_comb begin
    addra_a[0] = ifc0.addra; dina_a[0] = ifc0.dina; wea_a[0] = ifc0.wea;
    busy_a[0]  = ifc0.busy;  done_a[0] = ifc0.done; sum_a[0] = ifc0.sum;
    addra_a[1] = ifc1.addra; dina_a[1] = ifc1.dina; wea_a[1] = ifc1.wea;
    busy_a[1]  = ifc1.busy;  done_a[1] = ifc1.done; sum_a[1] = ifc1.sum;
  end

  // Behavioural RAMs (read-first) and the reference model of their contents.
  logic [15:0] mem  [2][65536];
  logic [15:0] mdl  [2][65536];
  logic [15:0] pipe [2][4];

  assign ifc0.douta = pipe[0][LAT0-1];
  assign ifc1.douta = pipe[1][LAT1-1];

  always @(posedge clka) begin
    for (int i = 0; i < 2; i++) begin
      pipe[i][0] <= mem[i][addra_a[i]];
      for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
      if (wea_a[i]) mem[i][addra_a[i]] = dina_a[i];
    end
  end

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d actual=%h expected=%h (cycle %0d)", name, inst, act, exp, cyc);
    end
  endtask

  typedef struct { int i; logic [15:0] a; logic [15:0] d; } wr_t;
  typedef struct { int i; logic [31:0] sum; int cyc; } dn_t;
  wr_t wq [$];
  dn_t dq [$];

  logic [15:0] prev_a [2];

  // Monitor: every write and every done pulse must match the next prediction.
  always @(negedge clka) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (wea_a[i]) begin
          chk("addr_stable_in_write", i, 32'(addra_a[i]), 32'(prev_a[i]));
          chk("busy_in_write", i, 32'(busy_a[i]), 32'd1);
          if (wq.size() == 0) begin
            chk("write_expected", i, 32'd0, 32'd1);
          end else begin
            wr_t e;
            e = wq.pop_front();
            chk("write_inst", i, 32'(i), 32'(e.i));
            chk("write_addr", i, 32'(addra_a[i]), 32'(e.a));
            chk("write_data", i, 32'(dina_a[i]), 32'(e.d));
          end
        end else if (dina_a[i] !== 16'h0) begin
          chk("dina_idle_zero", i, 32'(dina_a[i]), 32'd0);
        end
        if (done_a[i]) begin
          chk("busy_low_in_done", i, 32'(busy_a[i]), 32'd0);
          if (dq.size() == 0) begin
            chk("done_expected", i, 32'd0, 32'd1);
          end else begin
            dn_t d;
            d = dq.pop_front();
            chk("done_inst", i, 32'(i), 32'(d.i));
            chk("done_sum", i, sum_a[i], d.sum);
            chk("done_cycle", i, 32'(cyc), 32'(d.cyc));
          end
        end
        prev_a[i] = addra_a[i];
      end
    end
  end

  task automatic drive(input int i, input logic s, input logic [15:0] b, input logic [15:0] l);
    if (i == 0) begin
      ifc0.start = s; ifc0.base = b; ifc0.len = l;
    end else begin
      ifc1.start = s; ifc1.base = b; ifc1.len = l;
    end
  endtask

  task automatic preload(input int i, input logic [15:0] a, input logic [15:0] v);
    mem[i][a] = v;
    mdl[i][a] = v;
  endtask

  // Pulses start and predicts the first nexp word updates of the sweep.
  task automatic issue(input int i, input logic [15:0] b, input logic [15:0] l,
                       input int nexp, input bit exp_done);
    int          lat;
    logic [31:0] s;
    logic [15:0] a;
    logic [15:0] old;
    lat = (i == 0) ? LAT0 : LAT1;
    s   = 32'h0;
    @(negedge clka);
    drive(i, 1'b1, b, l);
    for (int k = 0; k < nexp; k++) begin
      a   = b + 16'(k);
      old = mdl[i][a];
      s   = s + 32'(old);
      mdl[i][a] = old + a;
      wq.push_back('{i, a, old + a});
    end
    if (exp_done) dq.push_back('{i, s, cyc + 1 + int'(l) * (lat + 2)});
    @(negedge clka);
    drive(i, 1'b0, 16'($urandom), 16'($urandom));
  endtask

  task automatic wait_done(input int i, input int budget);
    int n;
    n = 0;
    while (!done_a[i] && n < budget) begin
      @(negedge clka);
      n++;
    end
    if (!done_a[i]) chk("done_timeout", i, 32'd0, 32'd1);
    @(negedge clka);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          nbad;
    int          i;
    logic [15:0] b;
    logic [15:0] l;
    for (int n = 0; n < 65536; n++) begin
      mem[0][n] = 16'(n); mdl[0][n] = 16'(n);
      mem[1][n] = 16'(n); mdl[1][n] = 16'(n);
    end
    rst = 1'b1;
    drive(0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 16'h0, 16'h0);
    repeat (2) @(negedge clka);
    for (int k = 0; k < 2; k++) begin
      chk("rst_addra", k, 32'(addra_a[k]), 32'd0);
      chk("rst_wea",   k, 32'(wea_a[k]),   32'd0);
      chk("rst_dina",  k, 32'(dina_a[k]),  32'd0);
      chk("rst_busy",  k, 32'(busy_a[k]),  32'd0);
      chk("rst_done",  k, 32'(done_a[k]),  32'd0);
      chk("rst_sum",   k, sum_a[k],        32'd0);
    end
    prev_a[0] = addra_a[0];
    prev_a[1] = addra_a[1];
    rst = 1'b0;
    @(negedge clka);

    // Identity preload, short window.
    issue(0, 16'h0010, 16'd4, 4, 1'b1);
    wait_done(0, 40);

    // Empty sweep.
    issue(0, 16'h1234, 16'd0, 0, 1'b1);
    wait_done(0, 10);

    // Address wrap with saturated words.
    for (int k = 0; k < 4; k++) preload(0, 16'hFFFE + 16'(k), 16'hFFFF);
    issue(0, 16'hFFFE, 16'd4, 4, 1'b1);
    wait_done(0, 40);

    // Longer read latency.
    preload(1, 16'h0000, 16'd7);
    preload(1, 16'h0001, 16'd9);
    issue(1, 16'h0000, 16'd2, 2, 1'b1);
    wait_done(1, 40);

    // Reset in the wait phase of word 3 of an 8-word sweep.
    issue(0, 16'h0100, 16'd8, 3, 1'b0);
    repeat (10) @(negedge clka);
    rst = 1'b1;
    @(negedge clka);
    chk("abort_wea",  0, 32'(wea_a[0]),  32'd0);
    chk("abort_busy", 0, 32'(busy_a[0]), 32'd0);
    chk("abort_sum",  0, sum_a[0],       32'd0);
    chk("abort_pending_writes", 0, 32'(wq.size()), 32'd0);
    rst = 1'b0;
    prev_a[0] = addra_a[0];
    prev_a[1] = addra_a[1];
    @(negedge clka);
    for (int k = 3; k < 8; k++)
      chk("abort_word_untouched", 0, 32'(mem[0][16'h0100 + 16'(k)]), 32'(16'h0100 + 16'(k)));
    issue(0, 16'h0100, 16'd8, 8, 1'b1);
    wait_done(0, 60);

    // Start re-pulsed mid-sweep must be ignored.
    issue(1, 16'h0200, 16'd3, 3, 1'b1);
    repeat (4) @(negedge clka);
    drive(1, 1'b1, 16'h0300, 16'd5);
    @(negedge clka);
    drive(1, 1'b0, 16'h0300, 16'd5);
    wait_done(1, 60);

    // Randomized sweeps, with stray starts mid-sweep and in the done cycle.
    for (int r = 0; r < 24; r++) begin
      i = int'($urandom % 2);
      b = 16'($urandom);
      l = 16'($urandom % 7);
      for (int k = 0; k < int'(l); k++) preload(i, b + 16'(k), 16'($urandom));
      issue(i, b, l, int'(l), 1'b1);
      if (l != 0 && ($urandom % 2) == 1) begin
        @(negedge clka);
        drive(i, 1'b1, 16'($urandom), 16'($urandom));
        @(negedge clka);
        drive(i, 1'b0, 16'h0, 16'h0);
      end
      while (!done_a[i] && cyc < 100000) @(negedge clka);
      if (($urandom % 2) == 1) drive(i, 1'b1, 16'($urandom), 16'($urandom));
      wait_done(i, 4);
      drive(i, 1'b0, 16'h0, 16'h0);
      repeat (2) @(negedge clka);
    end

    repeat (4) @(negedge clka);
    chk("writes_all_seen", 0, 32'(wq.size()), 32'd0);
    chk("dones_all_seen",  0, 32'(dq.size()), 32'd0);
    nbad = 0;
    for (int k = 0; k < 2; k++)
      for (int n = 0; n < 65536; n++)
        if (mem[k][n] !== mdl[k][n]) nbad++;
    chk("ram_contents", 0, 32'(nbad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
